// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - mode encoding, initial patterns and reset period for the LED sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [3:0] LED_INIT_OFF    = 4'b0000;
  localparam logic [3:0] LED_INIT_ROTATE = 4'b0001;
  localparam logic [3:0] LED_INIT_BOUNCE = 4'b0001;
  localparam logic [3:0] LED_INIT_BLINK  = 4'b1111;

  // 0.5 s per step on the 50 MHz board clock
  localparam int unsigned DEFAULT_PERIOD = 25_000_000;

  // First pattern shown when a mode is (re)applied
  function automatic logic [3:0] init_pattern(input mode_e m);
    logic [3:0] p;
    p = LED_INIT_OFF;
    case (m)
      MODE_OFF:    p = LED_INIT_OFF;
      MODE_ROTATE: p = LED_INIT_ROTATE;
      MODE_BOUNCE: p = LED_INIT_BOUNCE;
      MODE_BLINK:  p = LED_INIT_BLINK;
      default:     p = LED_INIT_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// rtl/led_sequencer_if.sv - valid/ready command port of the LED sequencer
interface led_sequencer_if #(
  parameter int DIV_W = 26
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [DIV_W-1:0] cmd_period;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_period,
    output cmd_ready
  );

endinterface

// File: rtl/led_sequencer_step_timer.sv
// rtl/led_sequencer_step_timer.sv - prescaler producing one tick every period clocks
module step_timer #(
  parameter int DIV_W = 26
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] period_i,
  input  logic             restart_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] last_cnt;

  // A period of 0 behaves like 1, so the terminal count is clamped at 0.
  // The >= compare keeps the counter from running away if the period ever
  // shrinks below the current count.
  assign last_cnt = (period_i == '0) ? '0 : period_i - DIV_W'(1);
  assign tick_o   = (cnt_q >= last_cnt);

  // Next count: wrap on tick or explicit restart, otherwise increment
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - commandable step-pattern controller for the 4-LED bank
module led_sequencer #(
  parameter int          DIV_W          = 26,
  parameter int unsigned DEFAULT_PERIOD = led_seq_pkg::DEFAULT_PERIOD
) (
  input  logic             clk_50M,
  input  logic             rst,
  led_sequencer_if.slave   cmd,
  output logic [3:0]       led,
  output logic [1:0]       mode,
  output logic             step_pulse
);

  import led_seq_pkg::*;

  mode_e            mode_q;
  logic [DIV_W-1:0] period_q;
  logic [3:0]       led_q;
  logic             dir_up_q;
  logic             step_pulse_q;

  logic             slot_full_q;
  mode_e            slot_mode_q;
  logic [DIV_W-1:0] slot_period_q;

  logic             tick;
  logic             accept;
  logic             apply;
  logic [3:0]       adv_led_d;
  logic             adv_dir_up_d;

  // The slot is only refilled while empty and only drained on a tick, so
  // accept and apply can never fire in the same cycle.
  assign accept = cmd.cmd_valid & ~slot_full_q;
  assign apply  = tick & slot_full_q;

  step_timer #(
    .DIV_W(DIV_W)
  ) u_step_timer (
    .clk_i    (clk_50M),
    .rst_i    (rst),
    .period_i (period_q),
    .restart_i(apply),
    .tick_o   (tick)
  );

  // Next pattern when the current mode advances by one step
  always_comb begin
    adv_led_d    = led_q;
    adv_dir_up_d = dir_up_q;
    case (mode_q)
      MODE_OFF:    adv_led_d = LED_INIT_OFF;
      MODE_ROTATE: adv_led_d = {led_q[2:0], led_q[3]};
      MODE_BOUNCE: begin
        if (dir_up_q) begin
          if (led_q == 4'b1000) begin
            adv_led_d    = 4'b0100;
            adv_dir_up_d = 1'b0;
          end else begin
            adv_led_d = {led_q[2:0], 1'b0};
          end
        end else begin
          if (led_q == 4'b0001) begin
            adv_led_d    = 4'b0010;
            adv_dir_up_d = 1'b1;
          end else begin
            adv_led_d = {1'b0, led_q[3:1]};
          end
        end
      end
      MODE_BLINK:  adv_led_d = ~led_q;
      default:     adv_led_d = led_q;
    endcase
  end

  // Holding slot and pattern state: apply a pending command on a tick,
  // otherwise advance the pattern on a tick and capture new commands
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      mode_q        <= MODE_ROTATE;
      period_q      <= DIV_W'(DEFAULT_PERIOD);
      led_q         <= LED_INIT_ROTATE;
      dir_up_q      <= 1'b1;
      step_pulse_q  <= 1'b0;
      slot_full_q   <= 1'b0;
      slot_mode_q   <= MODE_OFF;
      slot_period_q <= '0;
    end else begin
      step_pulse_q <= tick;
      if (apply) begin
        mode_q      <= slot_mode_q;
        period_q    <= slot_period_q;
        led_q       <= init_pattern(slot_mode_q);
        dir_up_q    <= 1'b1;
        slot_full_q <= 1'b0;
      end else begin
        if (tick) begin
          led_q    <= adv_led_d;
          dir_up_q <= adv_dir_up_d;
        end
        if (accept) begin
          slot_full_q   <= 1'b1;
          slot_mode_q   <= mode_e'(cmd.cmd_mode);
          slot_period_q <= cmd.cmd_period;
        end
      end
    end
  end

  assign cmd.cmd_ready = ~slot_full_q;
  assign led           = led_q;
  assign mode          = mode_q;
  assign step_pulse    = step_pulse_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - scoreboard bench for the LED sequencer
module tb_led_sequencer;

  localparam int DIV_W = 26;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] led;
  logic [1:0] mode;
  logic       step_pulse;

  int total    = 0;
  int bad      = 0;
  int cyc      = 0;
  int last_cyc = 0;

  typedef struct {
    logic [3:0] led;
    logic [1:0] mode;
    int         gap;
    logic       rdy;
  } exp_t;

  exp_t sb[$];

  led_sequencer_if #(.DIV_W(DIV_W)) cmd_if ();

  led_sequencer #(
    .DIV_W         (DIV_W),
    .DEFAULT_PERIOD(4)
  ) dut (
    .clk_50M   (clk),
    .rst       (rst),
    .cmd       (cmd_if.slave),
    .led       (led),
    .mode      (mode),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every strobe pops one expectation: pattern, mode, spacing, ready
  always @(negedge clk) begin
    if (!rst && step_pulse === 1'b1) begin
      exp_t e;
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("step_led", 32'(led), 32'(e.led));
        check("step_mode", 32'(mode), 32'(e.mode));
        check("step_gap", 32'(cyc - last_cyc), 32'(e.gap));
        check("step_ready", 32'(cmd_if.cmd_ready), 32'(e.rdy));
      end
      last_cyc = cyc;
    end
  end

  task automatic push(input logic [3:0] l, input logic [1:0] m, input int g, input logic r);
    exp_t e;
    e.led  = l;
    e.mode = m;
    e.gap  = g;
    e.rdy  = r;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic send_cmd(input logic [1:0] m, input int unsigned p);
    logic ok;
    int   n;
    n = 0;
    cmd_if.cmd_mode   = m;
    cmd_if.cmd_period = DIV_W'(p);
    cmd_if.cmd_valid  = 1'b1;
    do begin
      ok = cmd_if.cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 64);
    cmd_if.cmd_valid = 1'b0;
    check("cmd_accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_mode   = 2'd0;
    cmd_if.cmd_period = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_cyc = cyc;

    // reset defaults: rotate every 4 clocks
    check("rst_led", 32'(led), 32'h1);
    check("rst_mode", 32'(mode), 32'h1);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'h1);
    check("rst_pulse", 32'(step_pulse), 32'h0);
    push(4'b0010, 2'd1, 4, 1'b1);
    push(4'b0100, 2'd1, 4, 1'b1);
    push(4'b1000, 2'd1, 4, 1'b1);
    push(4'b0001, 2'd1, 4, 1'b1);
    drain("defaults", 40);

    // bounce with period 3, applied at the next old-period tick
    do_reset();
    push(4'b0001, 2'd2, 4, 1'b1);
    push(4'b0010, 2'd2, 3, 1'b1);
    push(4'b0100, 2'd2, 3, 1'b1);
    push(4'b1000, 2'd2, 3, 1'b1);
    push(4'b0100, 2'd2, 3, 1'b1);
    push(4'b0010, 2'd2, 3, 1'b1);
    push(4'b0001, 2'd2, 3, 1'b1);
    push(4'b0010, 2'd2, 3, 1'b1);
    send_cmd(2'd2, 3);
    check("bounce_ready_low", 32'(cmd_if.cmd_ready), 32'h0);
    drain("bounce", 60);

    // back-pressure: BLINK/5 then OFF/2 offered back to back
    do_reset();
    push(4'b1111, 2'd3, 4, 1'b1);
    push(4'b0000, 2'd0, 5, 1'b1);
    push(4'b0000, 2'd0, 2, 1'b1);
    push(4'b0000, 2'd0, 2, 1'b1);
    push(4'b0000, 2'd0, 2, 1'b1);
    send_cmd(2'd3, 5);
    check("bp_ready_low_first", 32'(cmd_if.cmd_ready), 32'h0);
    send_cmd(2'd0, 2);
    check("bp_ready_low_second", 32'(cmd_if.cmd_ready), 32'h0);
    check("bp_led_blink", 32'(led), 32'hF);
    drain("backpressure", 60);

    // accept in the same cycle as a tick
    do_reset();
    push(4'b0010, 2'd1, 4, 1'b0);
    push(4'b1111, 2'd3, 4, 1'b1);
    push(4'b0000, 2'd3, 2, 1'b1);
    push(4'b1111, 2'd3, 2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    send_cmd(2'd3, 2);
    check("simul_ready_low", 32'(cmd_if.cmd_ready), 32'h0);
    drain("simultaneous", 60);

    // period 0 behaves as period 1
    do_reset();
    push(4'b0001, 2'd1, 4, 1'b1);
    push(4'b0010, 2'd1, 1, 1'b1);
    push(4'b0100, 2'd1, 1, 1'b1);
    push(4'b1000, 2'd1, 1, 1'b1);
    push(4'b0001, 2'd1, 1, 1'b1);
    send_cmd(2'd1, 0);
    drain("period0", 40);

    // reset while a command is pending in BLINK mode
    do_reset();
    push(4'b1111, 2'd3, 4, 1'b1);
    send_cmd(2'd3, 6);
    drain("midrst_blink", 40);
    send_cmd(2'd0, 3);
    check("midrst_slot_full", 32'(cmd_if.cmd_ready), 32'h0);
    check("midrst_mode_blink", 32'(mode), 32'h3);
    do_reset();
    check("midrst_led", 32'(led), 32'h1);
    check("midrst_mode", 32'(mode), 32'h1);
    check("midrst_ready", 32'(cmd_if.cmd_ready), 32'h1);
    check("midrst_pulse", 32'(step_pulse), 32'h0);
    push(4'b0010, 2'd1, 4, 1'b1);
    push(4'b0100, 2'd1, 4, 1'b1);
    drain("midrst_after", 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Step-pattern controller for the board's 4-LED bank. It replaces the fixed one-hot rotate blinker with a commandable sequencer. Firmware or a debug UART selects a pattern mode and step period over a valid/ready command port. Commands take effect only at step boundaries so the LED bank never shows a partial pattern. The block sits between the command source and the `led[3:0]` pads, running on the 50 MHz board clock.

## Interface

- `DIV_W`, 26: width of the period field and of the prescaler counter.
- `DEFAULT_PERIOD`, 25_000_000: clocks per step after reset (0.5 s at 50 MHz).
- `clk_50M`, in, 1: board clock; the only clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: holding slot empty; command accepted when `cmd_valid & cmd_ready`.
- `cmd_mode`, in, 2: 0 OFF, 1 ROTATE, 2 BOUNCE, 3 BLINK.
- `cmd_period`, in, DIV_W: clocks per step; 0 is treated as 1.
- `led`, out, 4: LED drive, active-high, registered.
- `mode`, out, 2: currently applied mode, registered.
- `step_pulse`, out, 1: one-cycle strobe, high in the cycle `led` takes a new value.

## Operation

- **Reset state:** `mode`=ROTATE, period=`DEFAULT_PERIOD`, `led`=4'b0001, bounce direction=up, `cnt`=0, holding slot empty, `cmd_ready`=1, `step_pulse`=0.
- **Prescaler:** `cnt` counts 0..period-1. `tick` is asserted when `cnt`==period-1, and `cnt` then wraps to 0. With period 1, `tick` is asserted every cycle.
- **Command acceptance:** mode and period are captured into the one-entry holding slot. `cmd_ready` drops the cycle after acceptance. While the slot is full, `cmd_valid` is ignored and the command must be held by the source.
- **On a `tick` with the slot full (apply):**
  - Load mode and period.
  - Set `cnt`=0.
  - Load the initial pattern: OFF 0000, ROTATE 0001, BOUNCE 0001 with direction up, BLINK 1111.
  - Empty the slot and set `cmd_ready`=1.
- **On a `tick` with the slot empty (advance):**
  - ROTATE: `led` <= {led[2:0], led[3]}.
  - BOUNCE: shift left while direction is up. At 1000, reverse direction and shift right. At 0001, reverse direction back to up. The sequence is 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, and so on.
  - BLINK: `led` <= ~`led`.
  - OFF: `led` stays 0000.
- **Accept and `tick` in the same cycle:** the `tick` advances the old pattern, and the new command is applied at the following `tick`, timed with the old period.
- **Reapplying the current mode:** this still restarts the pattern from its initial value.
- **`rst` mid-step or with the slot full:** the pending command is discarded and all state returns to the reset values on the next edge.

## Timing

- `led`, `mode` and `step_pulse` all update on the clock edge where `tick` is sampled high. `step_pulse` is high for exactly the following cycle, including on apply and in OFF mode.
- **Steady-state spacing:** consecutive `step_pulse` strobes are exactly `period` cycles apart.
- **Command latency:** from acceptance to apply, 1 to old-period cycles.
- **After apply:** the first advance occurs exactly new-period cycles later.
- **Period arithmetic:** unsigned DIV_W bits. The maximum period is 2^DIV_W-1, with no overflow because `cnt` never exceeds period-1.

## Structure

- **Package `led_seq_pkg`:**
  - Mode encoding enum: `MODE_OFF`, `MODE_ROTATE`, `MODE_BOUNCE`, `MODE_BLINK`.
  - Initial-pattern constants.
  - `DEFAULT_PERIOD`.
- **Sub-module `step_timer`:** contains the prescaler. It takes period and restart inputs and outputs `tick`. It is sync-reset and parameterised by `DIV_W`.
- **Top level:** holds the holding slot, the pattern state machine and the bounce direction flag.

## Test plan

- **Reset defaults:** run with `DEFAULT_PERIOD` overridden to 4 and no commands.
  - `led` must read 0001, 0010, 0100, 1000, 0001.
  - `step_pulse` must be asserted every 4 cycles.
- **BOUNCE:** send mode=2, period=3.
  - Apply occurs at the next `tick`.
  - `led` then follows 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, with 3 cycles between `step_pulse` strobes.
- **Back-pressure:** offer two back-to-back commands, BLINK/5 then OFF/2.
  - `cmd_ready`=0 after the first command until it is applied.
  - `led` goes 1111, then 0000 after 5 cycles, then holds.
  - The second command applies at that tick, after which `led` holds 0000 and `step_pulse` recurs every 2 cycles.
- **Simultaneous events:** accept a command in the same cycle as a `tick`.
  - The old pattern advances once.
  - The new mode applies exactly old-period cycles later.
- **Period 0:** send ROTATE/0.
  - Treated as period 1: `led` rotates and `step_pulse` is high every cycle.
- **Mid-operation reset:** assert `rst` for one cycle while the slot is full in BLINK mode.
  - The next cycle shows `led`=0001, `mode`=ROTATE and `cmd_ready`=1.
  - The pending command is never applied.
